jtag_host: RTL and testbench

JTAG_HOST -- requirements
Module: jtag_host

---
 rtl/jtag_host_pkg.sv | 49 ++++
 rtl/jtag_host_if.sv | 11 +
 rtl/jtag_host_synchronizer.sv | 23 ++
 rtl/jtag_host.sv | 182 ++++++++++++++++++
 tb/tb_jtag_host.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_host_pkg.sv
// Shared types for the JTAG host: command encoding, host FSM states and
// the per-command TMS header patterns.
package jtag_host_pkg;

  typedef enum logic [1:0] {
    CMD_RESET   = 2'd0,
    CMD_SCAN_IR = 2'd1,
    CMD_SCAN_DR = 2'd2
  } jtag_host_cmd_t;

  typedef enum logic [2:0] {
    HOST_IDLE,
    TRST,
    TMS_HEADER,
    SHIFT,
    TMS_TRAILER,
    DONE
  } host_state_t;

  localparam int TRST_PERIODS = 2;

  // TMS values for the header, first period in bit 0.
  typedef struct packed {
    logic [5:0] tms;
    logic [2:0] len;
  } tms_seq_t;

  // A zero-length scan goes Capture -> Exit1 directly, skipping Shift.
  // Any non-scan command gets the post-TRST walk to Run-Test/Idle.
  function automatic tms_seq_t header_seq(jtag_host_cmd_t cmd, logic empty);
    tms_seq_t s;
    case (cmd)
      CMD_SCAN_IR: begin
        s.tms = empty ? 6'b001011 : 6'b000011;
        s.len = 3'd4;
      end
      CMD_SCAN_DR: begin
        s.tms = empty ? 6'b000101 : 6'b000001;
        s.len = 3'd3;
      end
      default: begin
        s.tms = 6'b011111;
        s.len = 3'd6;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/jtag_host_if.sv
// JTAG pin bundle between the host and a target TAP.
interface jtag_interface;
  logic tck;
  logic tms;
  logic tdi;
  logic trst_n;
  logic tdo;

  modport host   (output tck, tms, tdi, trst_n, input  tdo);
  modport target (input  tck, tms, tdi, trst_n, output tdo);
endinterface

// File: rtl/jtag_host_synchronizer.sv
// Two-flop synchronizer for bringing asynchronous inputs into the clk domain.
module synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/jtag_host.sv
// JTAG host: runs one TAP reset or IR/DR scan per accepted command, with TCK
// derived from clk; TMS/TDI change on TCK falls, TDO is sampled on TCK rises.
module jtag_host
  import jtag_host_pkg::*;
#(
  parameter int CLK_DIVISOR = 8,
  parameter int MAX_SCAN    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  jtag_interface.host               jtag,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  jtag_host_cmd_t            cmd_type,
  input  logic [$clog2(MAX_SCAN):0] cmd_length,
  input  logic [MAX_SCAN-1:0]       cmd_data,
  output logic                      rsp_valid,
  output logic [MAX_SCAN-1:0]       rsp_data
);

  localparam int                LEN_W    = $clog2(MAX_SCAN) + 1;
  localparam int                IDX_W    = $clog2(MAX_SCAN);
  localparam logic [7:0]        DIV_LAST = 8'(CLK_DIVISOR - 1);
  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_SCAN);

  host_state_t         state;
  logic [7:0]          div_cnt;
  logic [2:0]          seq_cnt;
  logic [LEN_W-1:0]    bit_cnt;
  logic [LEN_W-1:0]    len;
  logic                is_reset;
  tms_seq_t            hdr;
  logic [MAX_SCAN-1:0] shift_reg;
  logic                tck_q, tms_q, tdi_q, trst_n_q;
  logic                tdo_sync;

  logic [LEN_W-1:0]    clamp_len;
  logic                reset_cmd;
  logic [2:0]          seq_next;
  logic                last_bit;

  synchronizer #(.WIDTH(1)) u_tdo_sync (
    .clk   (clk),
    .reset (reset),
    .d     (jtag.tdo),
    .q     (tdo_sync)
  );

  assign clamp_len = (cmd_length > MAX_LEN) ? MAX_LEN : cmd_length;
  assign reset_cmd = (cmd_type != CMD_SCAN_IR) && (cmd_type != CMD_SCAN_DR);
  assign seq_next  = seq_cnt + 3'd1;
  assign last_bit  = (bit_cnt == len - LEN_W'(1));

  assign jtag.tck    = tck_q;
  assign jtag.tms    = tms_q;
  assign jtag.tdi    = tdi_q;
  assign jtag.trst_n = trst_n_q;

  // NOTE: every register here is sequential state, so all updates use <=;
  // the reads below then see the pre-edge values of state, tck_q, etc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HOST_IDLE;
      div_cnt   <= '0;
      seq_cnt   <= '0;
      bit_cnt   <= '0;
      len       <= '0;
      is_reset  <= 1'b0;
      hdr       <= '0;
      shift_reg <= '0;
      tck_q     <= 1'b0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      trst_n_q  <= 1'b1;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        HOST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= reset_cmd ? TRST : TMS_HEADER;
            cmd_ready <= 1'b0;
            trst_n_q  <= !reset_cmd;
            is_reset  <= reset_cmd;
            len       <= clamp_len;
            hdr       <= header_seq(cmd_type, clamp_len == '0);
            shift_reg <= cmd_data;
            rsp_data  <= '0;
            seq_cnt   <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
          end
        end

        DONE: begin
          state     <= HOST_IDLE;
          cmd_ready <= 1'b1;
        end

        default: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= '0;
            tck_q   <= ~tck_q;
            if (!tck_q) begin
              // Rising TCK: the target's TDO has been stable since the last fall.
              if (state == SHIFT) rsp_data[bit_cnt[IDX_W-1:0]] <= tdo_sync;
            end else begin
              // Falling TCK ends a period: set TMS/TDI for the next one.
              case (state)
                TRST: begin
                  if (seq_cnt == 3'(TRST_PERIODS - 1)) begin
                    trst_n_q <= 1'b1;
                    state    <= TMS_HEADER;
                    seq_cnt  <= '0;
                    tms_q    <= hdr.tms[0];
                  end else begin
                    seq_cnt <= seq_next;
                    tms_q   <= 1'b1;
                  end
                end

                TMS_HEADER: begin
                  if (seq_cnt == hdr.len - 3'd1) begin
                    if (is_reset) begin
                      state     <= DONE;
                      rsp_valid <= 1'b1;
                      tms_q     <= 1'b1;
                    end else if (len == '0) begin
                      state   <= TMS_TRAILER;
                      seq_cnt <= '0;
                      tms_q   <= 1'b1;
                    end else begin
                      state     <= SHIFT;
                      tms_q     <= (len == LEN_W'(1));
                      tdi_q     <= shift_reg[0];
                      shift_reg <= shift_reg >> 1;
                    end
                  end else begin
                    seq_cnt <= seq_next;
                    tms_q   <= hdr.tms[seq_next];
                  end
                end

                SHIFT: begin
                  if (last_bit) begin
                    state   <= TMS_TRAILER;
                    seq_cnt <= '0;
                    tms_q   <= 1'b1;
                    tdi_q   <= 1'b0;
                  end else begin
                    bit_cnt   <= bit_cnt + LEN_W'(1);
                    tms_q     <= (bit_cnt + LEN_W'(2) == len);
                    tdi_q     <= shift_reg[0];
                    shift_reg <= shift_reg >> 1;
                  end
                end

                TMS_TRAILER: begin
                  if (seq_cnt == 3'd0) begin
                    seq_cnt <= 3'd1;
                    tms_q   <= 1'b0;
                  end else begin
                    state     <= DONE;
                    rsp_valid <= 1'b1;
                    tms_q     <= 1'b1;
                  end
                end

                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_host.sv
// Self-checking bench for jtag_host against a behavioural 1149.1 TAP with a
// 4-bit IR and a 32-bit loopback DR.
module tb_jtag_host;
  import jtag_host_pkg::*;

  localparam int D  = 4;
  localparam int MS = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  jtag_interface jtag ();

  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  jtag_host_cmd_t cmd_type = CMD_RESET;
  logic [5:0]     cmd_length = '0;
  logic [31:0]    cmd_data = '0;
  logic           rsp_valid;
  logic [31:0]    rsp_data;

  jtag_host #(.CLK_DIVISOR(D), .MAX_SCAN(MS)) dut (
    .clk        (clk),
    .reset      (reset),
    .jtag       (jtag),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_type   (cmd_type),
    .cmd_length (cmd_length),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data)
  );

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_t;

  function automatic tap_t tap_next(tap_t s, logic t);
    case (s)
      TLR:     return t ? TLR    : RTI;
      RTI:     return t ? SEL_DR : RTI;
      SEL_DR:  return t ? SEL_IR : CAP_DR;
      CAP_DR:  return t ? EX1_DR : SH_DR;
      SH_DR:   return t ? EX1_DR : SH_DR;
      EX1_DR:  return t ? UPD_DR : PAU_DR;
      PAU_DR:  return t ? EX2_DR : PAU_DR;
      EX2_DR:  return t ? UPD_DR : SH_DR;
      UPD_DR:  return t ? SEL_DR : RTI;
      SEL_IR:  return t ? TLR    : CAP_IR;
      CAP_IR:  return t ? EX1_IR : SH_IR;
      SH_IR:   return t ? EX1_IR : SH_IR;
      EX1_IR:  return t ? UPD_IR : PAU_IR;
      PAU_IR:  return t ? EX2_IR : PAU_IR;
      EX2_IR:  return t ? UPD_IR : SH_IR;
      default: return t ? SEL_DR : RTI;
    endcase
  endfunction

  tap_t        tap = TLR;
  logic [3:0]  ir = 4'h1;
  logic [3:0]  ir_sh = 4'h0;
  logic [31:0] dr_sh = '0;
  logic [31:0] dr_upd = '0;
  logic [31:0] cap_val = '0;
  int          shift_cnt = 0;

  always @(posedge jtag.tck or negedge jtag.trst_n) begin
    if (!jtag.trst_n) begin
      tap <= TLR;
      ir  <= 4'h1;
    end else begin
      case (tap)
        TLR:    ir <= 4'h1;
        CAP_DR: dr_sh <= cap_val;
        SH_DR:  begin dr_sh <= {jtag.tdi, dr_sh[31:1]}; shift_cnt <= shift_cnt + 1; end
        UPD_DR: dr_upd <= dr_sh;
        CAP_IR: ir_sh <= 4'b0001;
        SH_IR:  begin ir_sh <= {jtag.tdi, ir_sh[3:1]}; shift_cnt <= shift_cnt + 1; end
        UPD_IR: ir <= ir_sh;
        default: ;
      endcase
      tap <= tap_next(tap, jtag.tms);
    end
  end

  always @(negedge jtag.tck or negedge jtag.trst_n) begin
    if (!jtag.trst_n) jtag.tdo <= 1'b0;
    else jtag.tdo <= (tap == SH_DR) ? dr_sh[0] : (tap == SH_IR) ? ir_sh[0] : 1'b0;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    jtag_host_cmd_t cmd;
    logic [5:0]     len;
    logic [31:0]    data;
    logic [31:0]    cap;
    logic [31:0]    exp_rsp;
    logic [63:0]    exp_tms;
    int             exp_edges;
    int             exp_shifts;
    bit             chk_ir;
    logic [3:0]     exp_ir;
    bit             chk_dr;
    logic [31:0]    exp_dr;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic issue(input jtag_host_cmd_t t, input logic [5:0] l, input logic [31:0] d, input string tag);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready"}, 64'(cmd_ready), 64'(1));
    cmd_type = t; cmd_length = l; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check({tag, "_ready_drop"}, 64'(cmd_ready), 64'(0));
  endtask

  task automatic run_vec(input int i);
    vec_t        v = vecs[i];
    string       tag = $sformatf("v%0d", i);
    logic [63:0] tms_bits = '0;
    int          edges = 0, cyc = 0, trst_low, viol = 0, pulses = 0, s0, unstable = 0;
    logic        ptck, ptms, ptdi;
    logic [31:0] rsp_cap;
    bit          done = 0;

    cap_val = v.cap;
    s0 = shift_cnt;
    issue(v.cmd, v.len, v.data, tag);
    ptck = jtag.tck; ptms = jtag.tms; ptdi = jtag.tdi;
    trst_low = jtag.trst_n ? 0 : 1;
    while (!done && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
      if (!jtag.trst_n) trst_low++;
      if (!ptck && jtag.tck) begin
        if (edges < 64) tms_bits[edges] = jtag.tms;
        edges++;
      end
      if ((jtag.tms !== ptms || jtag.tdi !== ptdi) && !(ptck && !jtag.tck)) viol++;
      ptck = jtag.tck; ptms = jtag.tms; ptdi = jtag.tdi;
      if (rsp_valid) begin pulses++; done = 1; end
    end
    check({tag, "_done"}, 64'(done), 64'(1));
    rsp_cap = rsp_data;
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'(v.exp_rsp));
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid) pulses++;
      if (rsp_data !== rsp_cap) unstable++;
    end
    check({tag, "_pulses"}, 64'(pulses), 64'(1));
    check({tag, "_rsp_hold"}, 64'(unstable), 64'(0));
    check({tag, "_ready_back"}, 64'(cmd_ready), 64'(1));
    check({tag, "_idle_pins"}, 64'({jtag.tck, jtag.tms, jtag.trst_n}), 64'(3'b011));
    check({tag, "_edges"}, 64'(edges), 64'(v.exp_edges));
    check({tag, "_tms"}, tms_bits, v.exp_tms);
    check({tag, "_shifts"}, 64'(shift_cnt - s0), 64'(v.exp_shifts));
    check({tag, "_tap_rti"}, 64'(tap == RTI), 64'(1));
    check({tag, "_edge_align"}, 64'(viol), 64'(0));
    check({tag, "_duration"},
          64'((cyc >= v.exp_edges * 2 * D - 2) && (cyc <= v.exp_edges * 2 * D + 2)), 64'(1));
    check({tag, "_trst_low"}, 64'(trst_low), 64'((v.cmd == CMD_RESET) ? 4 * D : 0));
    if (v.chk_ir) check({tag, "_ir"}, 64'(ir), 64'(v.exp_ir));
    if (v.chk_dr) check({tag, "_dr"}, 64'(dr_upd), 64'(v.exp_dr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, s0, n, pulses;

    vecs[0] = '{cmd: CMD_RESET,   len: 6'd0,  data: 32'h0,         cap: 32'h0,
                exp_rsp: 32'h0,        exp_tms: 64'h7F,              exp_edges: 8,  exp_shifts: 0,
                chk_ir: 1'b1, exp_ir: 4'h1, chk_dr: 1'b0, exp_dr: 32'h0};
    vecs[1] = '{cmd: CMD_SCAN_IR, len: 6'd4,  data: 32'hA,         cap: 32'h0,
                exp_rsp: 32'h1,        exp_tms: 64'h183,             exp_edges: 10, exp_shifts: 4,
                chk_ir: 1'b1, exp_ir: 4'hA, chk_dr: 1'b0, exp_dr: 32'h0};
    vecs[2] = '{cmd: CMD_SCAN_IR, len: 6'd0,  data: 32'hF,         cap: 32'h0,
                exp_rsp: 32'h0,        exp_tms: 64'h1B,              exp_edges: 6,  exp_shifts: 0,
                chk_ir: 1'b1, exp_ir: 4'h1, chk_dr: 1'b0, exp_dr: 32'h0};
    vecs[3] = '{cmd: CMD_SCAN_DR, len: 6'd32, data: 32'hDEADBEEF,  cap: 32'h12345678,
                exp_rsp: 32'h12345678, exp_tms: 64'h0000_000C_0000_0001, exp_edges: 37, exp_shifts: 32,
                chk_ir: 1'b0, exp_ir: 4'h0, chk_dr: 1'b1, exp_dr: 32'hDEADBEEF};
    vecs[4] = '{cmd: CMD_SCAN_DR, len: 6'd0,  data: 32'hFFFFFFFF,  cap: 32'h55AA55AA,
                exp_rsp: 32'h0,        exp_tms: 64'h0D,              exp_edges: 5,  exp_shifts: 0,
                chk_ir: 1'b0, exp_ir: 4'h0, chk_dr: 1'b1, exp_dr: 32'h55AA55AA};
    vecs[5] = '{cmd: CMD_SCAN_DR, len: 6'd40, data: 32'h0F0F00FF,  cap: 32'hCAFEF00D,
                exp_rsp: 32'hCAFEF00D, exp_tms: 64'h0000_000C_0000_0001, exp_edges: 37, exp_shifts: 32,
                chk_ir: 1'b0, exp_ir: 4'h0, chk_dr: 1'b1, exp_dr: 32'h0F0F00FF};
    vecs[6] = '{cmd: CMD_SCAN_DR, len: 6'd1,  data: 32'h1,         cap: 32'h5,
                exp_rsp: 32'h1,        exp_tms: 64'h19,              exp_edges: 6,  exp_shifts: 1,
                chk_ir: 1'b0, exp_ir: 4'h0, chk_dr: 1'b1, exp_dr: 32'h80000002};
    vecs[7] = '{cmd: CMD_SCAN_DR, len: 6'd8,  data: 32'hFFFFFFA5,  cap: 32'h123456C3,
                exp_rsp: 32'hC3,       exp_tms: 64'hC01,             exp_edges: 13, exp_shifts: 8,
                chk_ir: 1'b0, exp_ir: 4'h0, chk_dr: 1'b1, exp_dr: 32'hA5123456};

    // Reset values, then 100 quiet clocks with no command.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_pins", 64'({jtag.tck, jtag.tms, jtag.tdi, jtag.trst_n}), 64'(4'b0101));
    check("rst_handshake", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (jtag.tck !== 1'b0 || jtag.tms !== 1'b1 || jtag.trst_n !== 1'b1 ||
          cmd_ready !== 1'b1 || rsp_valid !== 1'b0) bad++;
    end
    check("idle_100", 64'(bad), 64'(0));

    for (int i = 0; i < NV; i++) run_vec(i);

    // Abort a 32-bit DR scan during bit 10.
    cap_val = 32'hFFFFFFFF;
    s0 = shift_cnt;
    pulses = 0;
    issue(CMD_SCAN_DR, 6'd32, 32'h0, "abort");
    n = 0;
    while ((shift_cnt - s0) < 10 && n < 2000) begin
      @(posedge clk); #1; n++;
      if (rsp_valid) pulses++;
    end
    check("abort_reach_bit10", 64'(shift_cnt - s0), 64'(10));
    check("abort_partial_rsp", 64'(rsp_data != 32'h0), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("abort_pins", 64'({jtag.tck, jtag.tms, jtag.tdi, jtag.trst_n}), 64'(4'b0101));
    check("abort_handshake", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
    check("abort_rsp_data", 64'(rsp_data), 64'(0));
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid) pulses++;
    end
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) pulses++;
    end
    check("abort_no_rsp", 64'(pulses), 64'(0));
    check("abort_idle", 64'({cmd_ready, jtag.tck}), 64'(2'b10));

    run_vec(0);
    run_vec(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
